// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file widths, types and a popcount helper
package rf_pkg;
    localparam int REG_CNT = 32;
    localparam int REG_AW  = 5;
    localparam int XLEN    = 32;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;

    function automatic logic [5:0] popcnt(input logic [REG_CNT-1:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < REG_CNT; i++) c = c + 6'(v[i]);
        return c;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from i_ptr+1 upward
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx
);
    logic          found;
    logic [PW-1:0] k;

    // first valid requester after the last winner takes the grant
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 1; i <= N; i++) begin
            k = PW'((int'(i_ptr) + i) % N);
            if (!found && i_valid[k]) begin
                found      = 1'b1;
                o_grant[k] = 1'b1;
                o_idx      = k;
            end
        end
    end
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: register-file write-port arbiter with long-latency scoreboard
module rf_wb_ctrl
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_iss_valid,
    input  logic                    i_iss_long,
    input  reg_addr_t               i_iss_rd,
    input  reg_addr_t               i_iss_rs1,
    input  reg_addr_t               i_iss_rs2,
    output logic                    o_iss_stall,
    input  logic [NUM_REQ-1:0]      i_wb_valid,
    input  logic [NUM_REQ*5-1:0]    i_wb_rd,
    input  logic [NUM_REQ*XLEN-1:0] i_wb_data,
    output logic [NUM_REQ-1:0]      o_wb_ready,
    output logic                    o_rd_wren,
    output reg_addr_t               o_rd_addr,
    output xlen_t                   o_rd_data,
    output logic [5:0]              o_pend_cnt,
    output logic                    o_err
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0] LONG = PW'(NUM_REQ - 1);

    logic [REG_CNT-1:0] sb_q, sb_d;
    logic [PW-1:0]      ptr_q, ptr_d, gidx;
    logic               wren_q, wren_d, err_q, err_d;
    reg_addr_t          addr_q, addr_d, wb_rd_g;
    xlen_t              data_q, data_d, wb_data_g;
    logic [5:0]         cnt_q, cnt_d;
    logic               xfer, set_en, clr_en;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_valid (i_wb_valid),
        .i_ptr   (ptr_q),
        .o_grant (o_wb_ready),
        .o_idx   (gidx)
    );

    assign o_iss_stall = i_iss_valid & (sb_q[i_iss_rs1] | sb_q[i_iss_rs2] | sb_q[i_iss_rd]);
    assign o_rd_wren   = wren_q;
    assign o_rd_addr   = addr_q;
    assign o_rd_data   = data_q;
    assign o_pend_cnt  = cnt_q;
    assign o_err       = err_q;

    // next state: scoreboard set/clear, error detection, write-port capture
    always_comb begin
        wb_rd_g   = i_wb_rd[int'(gidx)*REG_AW +: REG_AW];
        wb_data_g = i_wb_data[int'(gidx)*XLEN +: XLEN];
        xfer      = |(i_wb_valid & o_wb_ready);
        set_en    = i_iss_valid & ~o_iss_stall & i_iss_long & (i_iss_rd != '0);
        clr_en    = xfer & (gidx == LONG) & (wb_rd_g != '0);
        sb_d      = sb_q;
        if (clr_en) sb_d[wb_rd_g] = 1'b0;
        if (set_en) sb_d[i_iss_rd] = 1'b1;
        sb_d[0]   = 1'b0;
        err_d     = err_q | (clr_en & (~sb_q[wb_rd_g] | (set_en & (i_iss_rd == wb_rd_g))));
        cnt_d     = popcnt(sb_d);
        wren_d    = xfer & (wb_rd_g != '0);
        addr_d    = xfer ? wb_rd_g : addr_q;
        data_d    = xfer ? wb_data_g : data_q;
        ptr_d     = xfer ? gidx : ptr_q;
    end

    // state registers; reset leaves requester 0 as next in line
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sb_q   <= '0;
            ptr_q  <= LONG;
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            sb_q   <= sb_d;
            ptr_q  <= ptr_d;
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: directed plus randomized checks against a behavioural model
module tb_rf_wb_ctrl;
    localparam int N = 2;
    localparam int L = N - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              iss_valid = 1'b0, iss_long = 1'b0;
    logic [4:0]        iss_rd = '0, iss_rs1 = '0, iss_rs2 = '0;
    logic              iss_stall;
    logic [N-1:0]      wb_valid = '0;
    logic [N*5-1:0]    wb_rd = '0;
    logic [N*32-1:0]   wb_data = '0;
    logic [N-1:0]      wb_ready;
    logic              rd_wren;
    logic [4:0]        rd_addr;
    logic [31:0]       rd_data;
    logic [5:0]        pend_cnt;
    logic              err;

    int n_tests = 0, n_fail = 0;
    bit m_pend[32];
    int m_ptr;
    bit m_wren, m_err, m_rst_seen;
    int m_addr;
    logic [31:0] m_data;
    int last_g;

    rf_wb_ctrl #(.NUM_REQ(N)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_iss_valid(iss_valid), .i_iss_long(iss_long), .i_iss_rd(iss_rd),
        .i_iss_rs1(iss_rs1), .i_iss_rs2(iss_rs2), .o_iss_stall(iss_stall),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
        .o_wb_ready(wb_ready), .o_rd_wren(rd_wren), .o_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_pend_cnt(pend_cnt), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pend_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    task automatic set_req(input int k, input bit v, input logic [4:0] rd, input logic [31:0] d);
        wb_valid[k]        = v;
        wb_rd[k*5 +: 5]    = rd;
        wb_data[k*32 +: 32] = d;
    endtask

    task automatic set_iss(input bit v, input bit lng, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        iss_valid = v; iss_long = lng; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
    endtask

    // one clock: check combinational outputs, clock, advance model, check registers
    task automatic step();
        int g;
        bit stl, set_b, clr_b;
        int grd;
        logic [31:0] gd;
        logic [N-1:0] exp_rdy;
        #2;
        g = -1;
        for (int i = 1; i <= N; i++)
            if (g < 0 && wb_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        stl = iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
        check("ready", 64'(wb_ready), 64'(exp_rdy));
        check("stall", 64'(iss_stall), 64'(stl));
        grd = (g >= 0) ? int'(wb_rd[g*5 +: 5]) : 0;
        gd  = (g >= 0) ? wb_data[g*32 +: 32] : 32'h0;
        set_b = iss_valid && !stl && iss_long && iss_rd != 0;
        clr_b = (g == L) && grd != 0;
        @(posedge clk);
        #1;
        last_g = g;
        if (rst) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_ptr = L; m_wren = 0; m_addr = 0; m_data = '0; m_err = 0; m_rst_seen = 1;
        end else begin
            if (clr_b && (!m_pend[grd] || (set_b && int'(iss_rd) == grd))) m_err = 1;
            if (clr_b) m_pend[grd] = 1'b0;
            if (set_b) m_pend[iss_rd] = 1'b1;
            m_wren = (g >= 0) && grd != 0;
            if (g >= 0) begin m_addr = grd; m_data = gd; m_ptr = g; end
            m_rst_seen = 0;
        end
        check("wren", 64'(rd_wren), 64'(m_wren));
        if (m_wren || m_rst_seen) begin
            check("addr", 64'(rd_addr), 64'(m_addr));
            check("data", 64'(rd_data), 64'(m_data));
        end
        check("pend_cnt", 64'(pend_cnt), 64'(pend_count()));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        wb_valid = '0;
        do_reset();
        check("rst_wren", 64'(rd_wren), 64'h0);
        check("rst_cnt", 64'(pend_cnt), 64'h0);

        // single pipeline write
        set_req(0, 1, 5'd5, 32'hDEADBEEF);
        step();
        check("t1_addr", 64'(rd_addr), 64'd5);
        check("t1_data", 64'(rd_data), 64'hDEADBEEF);
        set_req(0, 0, 0, 0);
        step();
        check("t1_idle", 64'(rd_wren), 64'h0);

        // alternating grants
        do_reset();
        set_req(0, 1, 5'd1, 32'h11);
        set_req(1, 1, 5'd2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            step();
            check("t2_alt", 64'(last_g), 64'(i % 2));
            check("t2_addr", 64'(rd_addr), 64'((i % 2) + 1));
        end
        set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);

        // RAW stall then release one cycle after the clear
        do_reset();
        set_iss(1, 1, 5'd7, 5'd0, 5'd0); step();
        check("t3_cnt", 64'(pend_cnt), 64'd1);
        set_iss(1, 0, 5'd8, 5'd1, 5'd7);
        set_req(L, 1, 5'd7, 32'h77);
        step();
        set_req(L, 0, 0, 0);
        step();
        check("t3_cnt0", 64'(pend_cnt), 64'd0);
        check("t3_err", 64'(err), 64'h0);

        // rd=0 is dropped
        set_iss(1, 1, 5'd0, 5'd0, 5'd0); step();
        set_iss(0, 0, 0, 0, 0);
        set_req(0, 1, 5'd0, 32'h55);
        step();
        check("t4_wren", 64'(rd_wren), 64'h0);
        set_req(0, 0, 0, 0);

        // spurious clear raises sticky error
        set_req(L, 1, 5'd9, 32'h99); step();
        set_req(L, 0, 0, 0);
        check("t5_err", 64'(err), 64'h1);
        set_req(0, 1, 5'd3, 32'h3); step(); set_req(0, 0, 0, 0); step();
        check("t5_sticky", 64'(err), 64'h1);

        // reset drops pending work
        set_iss(1, 1, 5'd3, 0, 0); step();
        set_iss(1, 1, 5'd4, 0, 0); step();
        set_iss(0, 0, 0, 0, 0);
        set_req(L, 1, 5'd3, 32'h33);
        do_reset();
        set_req(L, 0, 0, 0);
        set_iss(1, 0, 5'd10, 5'd3, 5'd0);
        step();
        check("t6_cnt", 64'(pend_cnt), 64'd0);

        // randomized traffic; requesters hold until accepted
        set_iss(0, 0, 0, 0, 0);
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!wb_valid[k] && $urandom_range(0, 2) == 0) begin
                    logic [4:0] r;
                    r = 5'($urandom_range(0, 7));
                    if (k == L && $urandom_range(0, 9) != 0)
                        for (int t = 0; t < 8; t++) begin
                            int q = $urandom_range(1, 7);
                            if (m_pend[q]) r = 5'(q);
                        end
                    set_req(k, 1, r, $urandom);
                end
            end
            set_iss($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            rst = ($urandom_range(0, 59) == 0);
            step();
            if (last_g >= 0) wb_valid[last_g] = 1'b0;
        end
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Write-port controller and register scoreboard for the 32x32 integer register file.
- Shares the register file's single write port between NUM_REQ writeback requesters: requester 0 is the in-order pipeline writeback; requester NUM_REQ-1 is the long-latency unit (LSU/divider).
- Grants by round-robin and drives the registered write port (rd_wren/rd_addr/rd_data).
- Tracks destination registers with pending long-latency writes, so issue can stall on RAW/WAW hazards.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..4); index NUM_REQ-1 is the long-latency port.
REG_CNT, 32, number of architectural registers; address width 5.
XLEN, 32, data width.

Ports:
i_clk  input  1  clock, rising edge.
i_reset  input  1  synchronous reset, active-high.
i_iss_valid  input  1  issue slot holds an instruction.
i_iss_long  input  1  issued instruction's rd is written by the long-latency port.
i_iss_rd  input  5  issue destination register.
i_iss_rs1  input  5  issue source register 1.
i_iss_rs2  input  5  issue source register 2.
o_iss_stall  output  1  issue must hold this cycle.
i_wb_valid  input  NUM_REQ  per-requester writeback valid.
i_wb_rd  input  NUM_REQ*5  per-requester destination, requester k at bits [5k+4:5k].
i_wb_data  input  NUM_REQ*XLEN  per-requester data.
o_wb_ready  output  NUM_REQ  one-hot grant; a transfer occurs when valid&ready.
o_rd_wren  output  1  register-file write enable.
o_rd_addr  output  5  register-file write address.
o_rd_data  output  XLEN  register-file write data.
o_pend_cnt  output  6  number of scoreboard bits set (0..31).
o_err  output  1  sticky protocol error.

Behaviour:
- Reset (i_reset high at a rising edge):
  - Scoreboard cleared; round-robin pointer set so requester 0 has highest priority.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_pend_cnt=0, o_err=0.
  - Combinational outputs follow from cleared state: o_iss_stall=0 unless i_iss_valid hits a pending bit (none after reset); o_wb_ready driven by current valids.
  - Reset mid-transfer discards the in-flight write; any pending long-latency results are forgotten.
- Arbitration:
  - Combinational grant over i_wb_valid, round-robin starting at pointer+1.
  - o_wb_ready is one-hot among valid requesters, or 0 when none are valid.
  - Pointer updates to the granted index only on a grant.
  - Requester must hold valid, rd and data stable until accepted.
- Write port:
  - Exactly 1-cycle latency: accepted transfer in cycle N → o_rd_wren/o_rd_addr/o_rd_data registered in cycle N+1.
  - No accept → o_rd_wren=0 next cycle; addr/data hold their previous values.
  - Accepted rd=0 → handshake completes, o_rd_wren=0 (write dropped).
- Scoreboard (32 bits, bit 0 hardwired 0):
  - Set: i_iss_valid & ~o_iss_stall & i_iss_long & rd!=0 sets bit rd at the edge.
  - Clear: accepted transfer on requester NUM_REQ-1 with rd!=0 clears bit rd at the edge.
  - Same-cycle set and clear of the same bit is impossible because of the WAW stall. If it occurs, set wins and o_err is set.
  - Clear of a bit that is not set → o_err set; bit stays 0.
  - o_err stays set until reset.
- Stall (combinational, registered scoreboard only, no same-cycle clear bypass):
  - o_iss_stall = i_iss_valid & (pend[rs1] | pend[rs2] | pend[rd]).
  - Index 0 never stalls.
  - Result: one bubble after a clear before a dependent issue proceeds.
- o_pend_cnt: registered popcount of the scoreboard; always equals the number of set bits after each edge.
- Short-latency writes (requesters other than NUM_REQ-1) never touch the scoreboard.
- Same-cycle write/read of the register file is handled by the register file's own bypass; this block adds none.

Decomposition:
- Package rf_pkg: REG_CNT, REG_AW=5, XLEN, typedef reg_addr_t (logic [4:0]), typedef xlen_t (logic [31:0]).
- Sub-module rr_arbiter (parameter N; inputs valid vector and pointer; outputs one-hot grant and granted index). It is purely combinational and reusable for other shared ports.
- Scoreboard, stall logic and write-port registers stay in rf_wb_ctrl.

Test Plan:
1. Reset, then requester 0 valid with rd=5, data=0xDEADBEEF → ready[0]=1 same cycle; next cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; following cycle o_rd_wren=0.
2. Both requesters valid continuously with rd=1/rd=2 → grants alternate 0,1,0,1 starting with 0; write port shows addr 1,2,1,2 one cycle delayed; no cycle grants both.
3. Issue long rd=7 → o_pend_cnt=1. Issue with rs2=7 → stall=1. Long port writes rd=7 → next cycle stall still 1 (no bypass) only if checked same cycle; cycle after accept stall=0, o_pend_cnt=0.
4. Issue long rd=0, then requester 0 writes rd=0 → no scoreboard bit, o_pend_cnt=0, o_rd_wren stays 0, handshake completes.
5. Long port writes rd=9 with no pending bit → o_err=1 and stays 1 through further traffic; clears only on i_reset.
6. Pend rd=3 and rd=4, assert i_reset while long port valid with rd=3 → next cycle o_pend_cnt=0, o_rd_wren=0, o_err=0, o_iss_stall=0 for rs1=3.
